// File: rtl/soc_system_pll_reset_ctrl_if.sv
// PLL reset/locked handshake plus the status outputs of the PLL reset controller.
// The master side is the controller and the slave side is the PLL/downstream observer.
interface soc_system_pll_reset_ctrl_if #(
  parameter int LOSS_CNT_W = 8
);
  logic                  pll_locked;
  logic                  sw_reset_req;
  logic                  pll_rst;
  logic                  sys_reset_n;
  logic                  pll_ready;
  logic [LOSS_CNT_W-1:0] lock_loss_count;
  logic                  timeout_err;
  logic [1:0]            state_o;

  modport master (
    input  pll_locked, sw_reset_req,
    output pll_rst, sys_reset_n, pll_ready, lock_loss_count, timeout_err, state_o
  );

  modport slave (
    output pll_locked, sw_reset_req,
    input  pll_rst, sys_reset_n, pll_ready, lock_loss_count, timeout_err, state_o
  );
endinterface

// File: rtl/soc_system_pll_reset_ctrl.sv
// Drives the fabric PLL reset and qualifies its locked signal over a stability window.
// It then releases a clean synchronous reset downstream, and retries on timeout or lock loss.
module soc_system_pll_reset_ctrl #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOSS_CNT_W          = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  soc_system_pll_reset_ctrl_if.master        bus
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_LAST     = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_PLL_RESET = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [1:0]             state_q, state_nx;
  logic [TIMER_W-1:0]     timer_q, timer_nx;
  logic                   loss_inc, timeout_set;
  logic [LOSS_CNT_W-1:0]  loss_q;
  logic                   timeout_q;
  logic                   pll_rst_q, sys_rst_n_q, ready_q;

  // pll_locked comes from the PLL's own clock domain; nothing else may look at it raw.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_nx    = state_q;
    timer_nx    = timer_q + 1'b1;
    loss_inc    = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      ST_PLL_RESET: begin
        if (bus.sw_reset_req) begin
          timer_nx = '0;
        end else if (timer_q == RST_LAST) begin
          state_nx = ST_WAIT_LOCK;
          timer_nx = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (bus.sw_reset_req) begin
          state_nx = ST_PLL_RESET;
          timer_nx = '0;
        end else if (locked_s) begin
          state_nx = ST_STABLE;
          timer_nx = '0;
        end else if (timer_q == TO_LAST) begin
          timeout_set = 1'b1;
          state_nx    = ST_PLL_RESET;
          timer_nx    = '0;
        end
      end
      ST_STABLE: begin
        if (bus.sw_reset_req) begin
          state_nx = ST_PLL_RESET;
          timer_nx = '0;
        end else if (!locked_s) begin
          // A drop before qualification completes is not a loss, just a restart.
          state_nx = ST_WAIT_LOCK;
          timer_nx = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_nx = ST_RUN;
          timer_nx = '0;
        end
      end
      ST_RUN: begin
        timer_nx = '0;
        if (!locked_s) begin
          loss_inc = 1'b1;
          state_nx = ST_PLL_RESET;
        end else if (bus.sw_reset_req) begin
          state_nx = ST_PLL_RESET;
        end
      end
      default: begin
        state_nx = ST_PLL_RESET;
        timer_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_PLL_RESET;
      timer_q <= '0;
    end else begin
      state_q <= state_nx;
      timer_q <= timer_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (loss_inc && !(&loss_q)) loss_q <= loss_q + 1'b1;
      if (timeout_set)            timeout_q <= 1'b1;
    end
  end

  // Outputs decode next-state so they switch on the same edge as state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      pll_rst_q   <= (state_nx == ST_PLL_RESET);
      sys_rst_n_q <= (state_nx == ST_RUN);
      ready_q     <= (state_nx == ST_RUN);
    end
  end

  assign bus.pll_rst         = pll_rst_q;
  assign bus.sys_reset_n     = sys_rst_n_q;
  assign bus.pll_ready       = ready_q;
  assign bus.lock_loss_count = loss_q;
  assign bus.timeout_err     = timeout_q;
  assign bus.state_o         = state_q;

endmodule

// File: tb/tb_soc_system_pll_reset_ctrl.sv
// Directed bench for the PLL reset controller: bring-up, lock loss, timeout,
// STABLE glitch, software re-reset and asynchronous reset, with hand-computed expectations.
module tb_soc_system_pll_reset_ctrl;
  localparam int LCW = 2;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  soc_system_pll_reset_ctrl_if #(.LOSS_CNT_W(LCW)) bus ();

  soc_system_pll_reset_ctrl #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32), .LOSS_CNT_W(LCW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] st);
    chk({tag, ".state"}, 32'(bus.state_o), 32'(st));
    chk({tag, ".pll_rst"}, 32'(bus.pll_rst), 32'(st == 2'd0));
    chk({tag, ".sys_reset_n"}, 32'(bus.sys_reset_n), 32'(st == 2'd3));
    chk({tag, ".pll_ready"}, 32'(bus.pll_ready), 32'(st == 2'd3));
  endtask

  // Entered PLL_RESET on the last edge with pll_locked already high (or high within 2 edges):
  // 4 edges of reset, 1 edge to see lock, 8 edges of qualification.
  task automatic relock_seq(input string tag);
    step(3);  chk_state({tag, ".rst3"}, 2'd0);
    step(1);  chk_state({tag, ".wait"}, 2'd1);
    step(1);  chk_state({tag, ".stab"}, 2'd2);
    step(7);  chk_state({tag, ".stab7"}, 2'd2);
    step(1);  chk_state({tag, ".run"}, 2'd3);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset_n          = 1'b0;
    bus.pll_locked   = 1'b0;
    bus.sw_reset_req = 1'b0;
    step(3);
    chk_state("por", 2'd0);
    chk("por.cnt", 32'(bus.lock_loss_count), 0);
    chk("por.terr", 32'(bus.timeout_err), 0);

    // Bring-up: pll_rst for 4 cycles, lock at cycle 10, RUN 11 edges later.
    reset_n = 1'b1;
    step(3);  chk_state("up.rst3", 2'd0);
    step(1);  chk_state("up.wait", 2'd1);
    step(6);
    bus.pll_locked = 1'b1;
    step(10); chk_state("up.edge10", 2'd2);
    step(1);  chk_state("up.edge11", 2'd3);

    // Four lock losses in RUN: count 1,2,3,3; sys_reset_n drops 3 edges after each.
    for (int k = 1; k <= 4; k++) begin
      bus.pll_locked = 1'b0;
      step(2); chk_state("loss.edge2", 2'd3);
      step(1); chk_state("loss.edge3", 2'd0);
      chk("loss.cnt", 32'(bus.lock_loss_count), (k > 3) ? 3 : k);
      bus.pll_locked = 1'b1;
      relock_seq("loss.relock");
    end

    // Timeout: lock never arrives, WAIT_LOCK lasts 32 cycles, retry repeats, error stays sticky.
    bus.pll_locked = 1'b0;
    step(3);  chk_state("to.drop", 2'd0);
    chk("to.cnt_sat", 32'(bus.lock_loss_count), 3);
    step(4);  chk_state("to.wait", 2'd1);
    step(31); chk_state("to.wait31", 2'd1);
    chk("to.terr0", 32'(bus.timeout_err), 0);
    step(1);  chk_state("to.retry", 2'd0);
    chk("to.terr1", 32'(bus.timeout_err), 1);
    step(3);  chk_state("to.rst3", 2'd0);
    step(1);  chk_state("to.wait2", 2'd1);
    step(31); chk_state("to.wait2_31", 2'd1);
    step(1);  chk_state("to.retry2", 2'd0);
    chk("to.terr_sticky", 32'(bus.timeout_err), 1);
    bus.pll_locked = 1'b1;
    relock_seq("to.relock");

    // Asynchronous reset in RUN takes effect before the next clock edge.
    reset_n = 1'b0;
    #1;
    chk_state("areset", 2'd0);
    chk("areset.cnt", 32'(bus.lock_loss_count), 0);
    chk("areset.terr", 32'(bus.timeout_err), 0);
    step(2);
    reset_n = 1'b1;
    relock_seq("areset.up");

    // Software re-reset alone leaves the loss count alone.
    bus.sw_reset_req = 1'b1;
    step(1);
    bus.sw_reset_req = 1'b0;
    chk_state("sw.only", 2'd0);
    chk("sw.only.cnt", 32'(bus.lock_loss_count), 0);
    relock_seq("sw.only.relock");

    // Software request in the same cycle the synchronized lock drops: one increment.
    bus.pll_locked = 1'b0;
    step(2); chk_state("sw.both.pre", 2'd3);
    bus.sw_reset_req = 1'b1;
    step(1);
    bus.sw_reset_req = 1'b0;
    chk_state("sw.both", 2'd0);
    chk("sw.both.cnt", 32'(bus.lock_loss_count), 1);
    bus.pll_locked = 1'b1;
    relock_seq("sw.both.relock");

    // One-cycle drop during qualification at count 5 restarts the full window, no loss.
    bus.sw_reset_req = 1'b1;
    step(1);
    bus.sw_reset_req = 1'b0;
    step(4); chk_state("gl.wait", 2'd1);
    step(1); chk_state("gl.stab", 2'd2);
    step(5);
    bus.pll_locked = 1'b0;
    step(1); chk_state("gl.a", 2'd2);
    bus.pll_locked = 1'b1;
    step(1); chk_state("gl.a1", 2'd2);
    step(1); chk_state("gl.back", 2'd1);
    chk("gl.cnt", 32'(bus.lock_loss_count), 1);
    step(1); chk_state("gl.restab", 2'd2);
    step(7); chk_state("gl.restab7", 2'd2);
    step(1); chk_state("gl.run", 2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
